program_loader: RTL and testbench

Receives a program image as a byte stream from the UART receiver and writes it, word by word, into the instruction/data BRAM through that memory's primary write port (`bram_en`/`bram_we`/`bram_addr`/`bram_wd`). It sits directly upstream of the BRAM and owns that port until loading finishes. It then raises `done` so the core can be released from reset.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_packer.sv | 33 +++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for program_loader and its byte_packer.
// The optional trailing checksum is enabled with PROGRAM_LOADER_CHECKSUM_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  function automatic logic is_terminal(input state_t s);
    return (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid is
// combinational and marks the byte that completes a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt_q;
  logic [23:0] shreg_q;

  // The completing byte lands in the top lane without an extra cycle.
  assign word       = {in_data, shreg_q};
  assign word_valid = in_valid && (cnt_q == LAST_BYTE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else if (in_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= {in_data, shreg_q[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian program image from the UART byte
// stream into BRAM; PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BRAM_SIZE = 32'h0000_6c00,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        bram_en,
  output logic        bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wd,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CSUM;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic        started_q;
  logic        accept;
  logic        word_valid;
  logic [31:0] word;
  logic        wr_d;
  logic        len_err;
  logic        done_d;
  logic        error_d;

  // Only the length and payload bytes go through the packer.
  assign accept    = rx_valid && ((state_q == S_LEN) || (state_q == S_DATA));
  assign dbg_state = state_q;

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (accept),
    .in_data    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= 8'd0;
    end else if (accept && (state_q == S_DATA)) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    len_err = 1'b0;
    case (state_q)
      S_LEN: begin
        if (word_valid) begin
          len_d = word;
          idx_d = 32'd0;
          if (word > BRAM_SIZE) begin
            state_d = S_ERR;
            len_err = 1'b1;
          end else if (word == 32'd0) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_valid) begin
          wr_d  = 1'b1;
          idx_d = idx_q + 32'd1;
          if (idx_q == (len_q - 32'd1)) begin
            state_d = AFTER_DATA;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // done/error trail the terminal state by one cycle so they follow the last
  // write pulse; a length error is flagged immediately since nothing is written.
  assign done_d  = done  || (state_q == S_DONE);
  assign error_d = error || (state_q == S_ERR) || len_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_LEN;
      len_q     <= 32'd0;
      idx_q     <= 32'd0;
      started_q <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= 32'd0;
      bram_wd   <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      started_q <= started_q || accept;
      bram_en   <= wr_d;
      bram_we   <= wr_d;
      if (wr_d) begin
        bram_addr <= BASE_ADDR + idx_q;
        bram_wd   <= word;
      end
      busy      <= !done_d && !error_d && !is_terminal(state_q) && (started_q || accept);
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected BRAM writes are queued as the
// stream is built and popped by a write monitor on the falling clock edge.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        bram_en, bram_we;
  logic [31:0] bram_addr, bram_wd;
  logic        busy, done, error;
  logic [2:0]  dbg_state;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];
  int          word_k;
  logic [7:0]  csum;
  logic        prev_we = 1'b0;

  always #5 clock = ~clock;

  program_loader dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_wd   (bram_wd),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the queue and last one cycle.
  always @(negedge clock) begin
    if (!reset && bram_we) begin
      check("pulse_width", 64'(prev_we), 64'd0);
      check("bram_en", 64'(bram_en), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        check("write", {bram_addr, bram_wd}, exp_q.pop_front());
      end
    end
    prev_we = bram_we;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom_range(0, 255));
    tick();
    rx_valid = 1'b0;
    tick();
    @(negedge clock);
    check("reset_ctrl", 64'({bram_en, bram_we, busy, done, error, dbg_state}), 64'd0);
    check("reset_bus", {bram_addr, bram_wd}, 64'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic start_stream(input logic [31:0] n);
    stream.delete();
    word_k = 0;
    csum   = 8'd0;
    for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      stream.push_back(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
    end
    exp_q.push_back({BASE + 32'(word_k), w});
    word_k++;
  endtask

  task automatic add_csum(input logic [7:0] flip);
    stream.push_back(csum ^ flip);
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stream.size(); i++) begin
      int gap;
      send_byte(stream[i]);
      gap = (i < stream.size() - 1) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        check("busy_gap", 64'(busy), 64'd1);
        tick();
      end
    end
  endtask

  task automatic finish_check(input logic exp_done, input logic exp_err);
    @(negedge clock);
    check("end_t1_flags", 64'({done, error}), 64'd0);
    @(negedge clock);
    check("end_done", 64'(done), 64'(exp_done));
    check("end_error", 64'(error), 64'(exp_err));
    check("end_busy", 64'(busy), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
    tick();
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    do_reset();

    // Basic two-word image, bytes back to back.
    start_stream(32'd2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add_csum(8'h00);
`endif
    send_stream(0);
    finish_check(1'b1, 1'b0);
    send_junk(5);
    check("done_sticky", 64'({done, error, busy}), 64'b100);

    // Length overflow: BRAM_SIZE + 1 words.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h6C);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clock);
    check("len_err_t1", 64'({done, error, busy}), 64'b010);
    tick();
    send_junk(8);
    check("len_err_sticky", 64'({done, error, busy}), 64'b010);

    // Empty image.
    do_reset();
    start_stream(32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add_csum(8'h00);
`endif
    send_stream(0);
    finish_check(1'b1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Single word with good, then bad, checksum.
    do_reset();
    start_stream(32'd1);
    add_word(32'h0403_0201);
    add_csum(8'h00);
    send_stream(0);
    finish_check(1'b1, 1'b0);
    do_reset();
    start_stream(32'd1);
    add_word(32'h0403_0201);
    add_csum(8'h01);
    send_stream(0);
    finish_check(1'b0, 1'b1);
`else
    do_reset();
    start_stream(32'd1);
    add_word(32'h0403_0201);
    send_stream(0);
    finish_check(1'b1, 1'b0);
`endif

    // Reset after 6 bytes, then the full image again.
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    do_reset();
    start_stream(32'd2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add_csum(8'h00);
`endif
    send_stream(0);
    finish_check(1'b1, 1'b0);

    // Random words with random gaps between bytes.
    do_reset();
    start_stream(32'd3);
    for (int i = 0; i < 3; i++) add_word($urandom);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add_csum(8'h00);
`endif
    send_stream(20);
    finish_check(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
